// File: rtl/rr_ff_arbiter_pkg.sv
// Shared types, FF_TYPE names and helpers for the round-robin flip-flop arbiter.
package ff_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } arb_state_e;

    localparam string FfTypeDff = "DFF";
    localparam string FfTypeTff = "TFF";

    // Widest one-hot vector onehot_to_idx accepts; callers zero-extend into it.
    localparam int unsigned OnehotMaxW = 32;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [OnehotMaxW-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < OnehotMaxW; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_ff_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr (with wrap) not excluded.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdxW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    input  logic [N_REQ-1:0] excl_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] cand;

    assign cand = req_i & ~excl_i;

    // Scan ptr+1, ptr+2, ... wrapping; the pointer itself is checked last.
    always_comb begin
        int unsigned j;
        j       = 0;
        win_o   = '0;
        valid_o = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            j = 32'(ptr_i) + off;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!valid_o && cand[j[IdxW-1:0]]) begin
                win_o[j[IdxW-1:0]] = 1'b1;
                valid_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_ff_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared
// WIDTH-bit register bank, with a bounded hold time per owner.
module rr_ff_arbiter
    import ff_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter string       FF_TYPE  = "DFF",
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned IdxW    = $clog2(N_REQ),
    localparam int unsigned HoldW   = $clog2(MAX_HOLD) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic                   busy,
    output logic [IdxW-1:0]        owner_id
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] bank_q, bank_nxt;
    logic [WIDTH-1:0] d_sel;
    logic             wr_en;

    logic             own_active;
    logic             hold_expired;
    logic [N_REQ-1:0] pick_excl;
    logic [N_REQ-1:0] pick_win;
    logic             pick_valid;
    logic [IdxW-1:0]  win_idx;

    // Owner still requesting while in OWN: this edge writes the bank.
    assign own_active   = (state_q == StOwn) && req[owner_q];
    assign hold_expired = own_active && (hold_q == HoldW'(MAX_HOLD - 1));
    // On hold expiry the current owner is skipped so someone else can win.
    assign pick_excl    = hold_expired ? gnt_q : '0;

    rr_pick #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .excl_i  (pick_excl),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    assign win_idx = IdxW'(onehot_to_idx(OnehotMaxW'(pick_win)));
    assign d_sel   = d_bus[32'(owner_q) * WIDTH +: WIDTH];

    // Next-state: grant, release, hold-limit handover and write enable.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StOwn;
                    gnt_d   = pick_win;
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    hold_d  = '0;
                end
            end
            StOwn: begin
                if (!req[owner_q]) begin
                    // Release: hand over directly or fall back to idle.
                    if (pick_valid) begin
                        gnt_d   = pick_win;
                        owner_d = win_idx;
                        ptr_d   = win_idx;
                        hold_d  = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else begin
                    wr_en = 1'b1;
                    if (hold_expired) begin
                        if (pick_valid) begin
                            gnt_d   = pick_win;
                            owner_d = win_idx;
                            ptr_d   = win_idx;
                        end
                        // Either a new owner or a re-grant: the count restarts.
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= IdxW'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Bank update flavour is fixed at elaboration.
    if (FF_TYPE == FfTypeDff) begin : g_dff
        assign bank_nxt = d_sel;
    end else if (FF_TYPE == FfTypeTff) begin : g_tff
        assign bank_nxt = bank_q ^ d_sel;
    end else begin : g_bad_ff_type
        $error("rr_ff_arbiter: FF_TYPE must be \"DFF\" or \"TFF\"");
        assign bank_nxt = d_sel;
    end

    // Shared register bank: written only by the owner while it still requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else if (wr_en) begin
            bank_q <= bank_nxt;
        end
    end

    assign gnt      = gnt_q;
    assign q        = bank_q;
    assign qbar     = ~bank_q;
    assign busy     = |gnt_q;
    assign owner_id = owner_q;

endmodule

// File: tb/tb_rr_ff_arbiter.sv
// Directed bench for rr_ff_arbiter: a DFF instance and a TFF instance, N_REQ=4, WIDTH=8.
module tb_rr_ff_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d_bus;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        busy;
    logic [1:0]  owner_id;

    logic [3:0]  req_t;
    logic [31:0] d_bus_t;
    logic [3:0]  gnt_t;
    logic [7:0]  q_t;
    logic [7:0]  qbar_t;
    logic        busy_t;
    logic [1:0]  owner_id_t;

    int unsigned n_vec;
    int unsigned n_err;

    rr_ff_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .FF_TYPE  ("DFF"),
        .MAX_HOLD (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .d_bus    (d_bus),
        .gnt      (gnt),
        .q        (q),
        .qbar     (qbar),
        .busy     (busy),
        .owner_id (owner_id)
    );

    rr_ff_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .FF_TYPE  ("TFF"),
        .MAX_HOLD (4)
    ) u_dut_tff (
        .clk      (clk),
        .rst      (rst),
        .req      (req_t),
        .d_bus    (d_bus_t),
        .gnt      (gnt_t),
        .q        (q_t),
        .qbar     (qbar_t),
        .busy     (busy_t),
        .owner_id (owner_id_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pass one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_q;
        int         prev_o;
        int         o;

        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        req     = 4'hF;
        d_bus   = '0;
        req_t   = 4'h0;
        d_bus_t = '0;

        // Reset dominates a full request vector.
        step();
        step();
        check_eq("rst gnt", 32'(gnt), 32'h0);
        check_eq("rst q", 32'(q), 32'h00);
        check_eq("rst qbar", 32'(qbar), 32'hFF);
        check_eq("rst busy", 32'(busy), 32'h0);
        check_eq("rst owner", 32'(owner_id), 32'h0);

        // Single requester: grant after one edge, write after the next.
        rst          = 1'b0;
        req          = 4'b0010;
        d_bus[15:8]  = 8'hA5;
        step();
        check_eq("single gnt", 32'(gnt), 32'h2);
        check_eq("single owner", 32'(owner_id), 32'h1);
        check_eq("single busy", 32'(busy), 32'h1);
        check_eq("single q before write", 32'(q), 32'h00);
        step();
        check_eq("single q", 32'(q), 32'hA5);
        check_eq("single qbar", 32'(qbar), 32'h5A);
        req = 4'b0000;
        step();
        check_eq("release gnt", 32'(gnt), 32'h0);
        check_eq("release busy", 32'(busy), 32'h0);
        check_eq("release owner held", 32'(owner_id), 32'h1);
        check_eq("release q held", 32'(q), 32'hA5);

        // Fairness: all request, each owner holds for four cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_bus[i*8 +: 8] = 8'h10 + 8'(i);
        end
        req = 4'hF;
        step();
        prev_o = 0;
        for (int r = 0; r < 5; r++) begin
            o = r % 4;
            for (int c = 0; c < 4; c++) begin
                if (!(r == 0 && c == 0)) begin
                    step();
                end
                if (c > 0) begin
                    exp_q = 8'h10 + 8'(o);
                end else if (r == 0) begin
                    exp_q = 8'h00;
                end else begin
                    exp_q = 8'h10 + 8'(prev_o);
                end
                check_eq($sformatf("fair r%0d c%0d gnt", r, c), 32'(gnt), 32'(1) << o);
                check_eq($sformatf("fair r%0d c%0d owner", r, c), 32'(owner_id), 32'(o));
                check_eq($sformatf("fair r%0d c%0d q", r, c), 32'(q), 32'(exp_q));
            end
            prev_o = o;
        end

        // No-bubble handover from owner 0 to requester 2.
        rst = 1'b1;
        step();
        rst          = 1'b0;
        d_bus        = '0;
        d_bus[7:0]   = 8'h11;
        d_bus[23:16] = 8'h22;
        req          = 4'b0001;
        step();
        check_eq("handover gnt0", 32'(gnt), 32'h1);
        step();
        check_eq("handover q0", 32'(q), 32'h11);
        req = 4'b0100;
        step();
        check_eq("handover gnt2", 32'(gnt), 32'h4);
        check_eq("handover busy", 32'(busy), 32'h1);
        check_eq("handover owner", 32'(owner_id), 32'h2);
        check_eq("handover no write", 32'(q), 32'h11);
        step();
        check_eq("handover q2", 32'(q), 32'h22);
        d_bus[23:16] = 8'h3C;
        step();
        check_eq("midrst pre q", 32'(q), 32'h3C);

        // Mid-operation reset, then requester 0 wins from the reset pointer.
        rst = 1'b1;
        req = 4'hF;
        step();
        check_eq("midrst gnt", 32'(gnt), 32'h0);
        check_eq("midrst q", 32'(q), 32'h00);
        check_eq("midrst qbar", 32'(qbar), 32'hFF);
        check_eq("midrst owner", 32'(owner_id), 32'h0);
        rst = 1'b0;
        step();
        check_eq("midrst regrant gnt", 32'(gnt), 32'h1);
        check_eq("midrst regrant owner", 32'(owner_id), 32'h0);

        // TFF: repeated writes of 0x0F toggle the bank; lone owner is re-granted on expiry.
        req_t         = 4'b0001;
        d_bus_t[7:0]  = 8'h0F;
        d_bus_t[15:8] = 8'hFF;
        step();
        check_eq("tff gnt", 32'(gnt_t), 32'h1);
        check_eq("tff q0", 32'(q_t), 32'h00);
        step();
        check_eq("tff q1", 32'(q_t), 32'h0F);
        check_eq("tff qbar1", 32'(qbar_t), 32'hF0);
        step();
        check_eq("tff q2", 32'(q_t), 32'h00);
        check_eq("tff qbar2", 32'(qbar_t), 32'hFF);
        step();
        check_eq("tff q3", 32'(q_t), 32'h0F);
        step();
        check_eq("tff expiry q4", 32'(q_t), 32'h00);
        check_eq("tff expiry regrant", 32'(gnt_t), 32'h1);
        step();
        check_eq("tff q5", 32'(q_t), 32'h0F);
        check_eq("tff q5 gnt", 32'(gnt_t), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
